// File: rtl/timeout_handler.sv
// rtl/timeout_handler.sv - watchdog timeout receiver: sync, shutdown request, drain window, forced stop
module timeout_handler #(
    parameter int SYNC_STAGES   = 2,
    parameter int DRAIN_CYCLES  = 100,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     timeout_in,
    input  logic                     shutdown_ack,
    output logic                     shutdown_req,
    output logic                     force_stop,
    output logic [1:0]               state,
    output logic [COUNTER_WIDTH-1:0] drain_count,
    output logic                     timeout_seen
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQUEST = 2'b01,
        CLEAN   = 2'b10,
        FORCED  = 2'b11
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] DRAIN_INIT = COUNTER_WIDTH'(DRAIN_CYCLES);

    generate
        if (64'(DRAIN_CYCLES) >= (64'd1 << COUNTER_WIDTH)) begin : g_bad_drain
            $error("timeout_handler: DRAIN_CYCLES does not fit in COUNTER_WIDTH");
        end
    endgenerate

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     timeout_sync;
    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     seen_q, seen_d;
    logic                     req_q, req_d;
    logic                     force_q, force_d;

    assign timeout_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], timeout_in};
        end
    end

    // Ack has priority over expiry; CLEAN and FORCED are terminal until reset.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        seen_d  = seen_q;
        case (state_q)
            IDLE: begin
                if (timeout_sync) begin
                    state_d = REQUEST;
                    count_d = DRAIN_INIT;
                    seen_d  = 1'b1;
                end
            end
            REQUEST: begin
                if (shutdown_ack) begin
                    state_d = CLEAN;
                end else if (count_q == '0) begin
                    state_d = FORCED;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            CLEAN: begin
                state_d = CLEAN;
            end
            FORCED: begin
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d   = (state_d == REQUEST) || (state_d == FORCED);
        force_d = (state_d == FORCED);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            seen_q  <= 1'b0;
            req_q   <= 1'b0;
            force_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            seen_q  <= seen_d;
            req_q   <= req_d;
            force_q <= force_d;
        end
    end

    assign state        = state_q;
    assign drain_count  = count_q;
    assign timeout_seen = seen_q;
    assign shutdown_req = req_q;
    assign force_stop   = force_q;

endmodule

// File: tb/tb_timeout_handler.sv
// tb/tb_timeout_handler.sv - self-checking bench for timeout_handler
module tb_timeout_handler;

    localparam int SYNC  = 2;
    localparam int DRAIN = 10;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          timeout_in = 1'b0;
    logic          shutdown_ack = 1'b0;
    logic          shutdown_req;
    logic          force_stop;
    logic [1:0]    state;
    logic [CW-1:0] drain_count;
    logic          timeout_seen;

    int tests = 0;
    int fails = 0;

    // snapshot layout: {state, shutdown_req, force_stop, timeout_seen, drain_count}
    typedef struct {
        string       name;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];

    timeout_handler #(
        .SYNC_STAGES  (SYNC),
        .DRAIN_CYCLES (DRAIN),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .timeout_in  (timeout_in),
        .shutdown_ack(shutdown_ack),
        .shutdown_req(shutdown_req),
        .force_stop  (force_stop),
        .state       (state),
        .drain_count (drain_count),
        .timeout_seen(timeout_seen)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] snap();
        return {state, shutdown_req, force_stop, timeout_seen, drain_count};
    endfunction

    function automatic exp_t mk(string name, logic [1:0] st, logic rq, logic fs, logic sn, int cnt);
        exp_t e;
        e.name = name;
        e.v    = {st, rq, fs, sn, CW'(cnt)};
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        timeout_in = 1'b0;
        shutdown_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Waits at negedges for state==REQUEST; returns edges waited, or -1 on timeout.
    task automatic wait_request(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (state == 2'b01) begin
                n = i;
                break;
            end
        end
        tests++;
        if (n < 0) begin
            fails++;
            $display("FAIL wait_request: state=%b never reached 01", state);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        logic [20:0] got;
        @(negedge clk);
        reset_n = 1'b0;
        timeout_in = 1'b1;
        shutdown_ack = 1'b0;
        sb.push_back(mk("reset", 2'b00, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        e = sb.pop_front(); got = snap(); tests++;
        if (got !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        timeout_in = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_clean_ack();
        exp_t e;
        logic [20:0] got;
        int n;
        do_reset();
        timeout_in = 1'b1;
        wait_request(n);
        tests++;
        if (n != SYNC + 1) begin fails++; $display("FAIL latency: got %0d edges expected %0d", n, SYNC + 1); end
        @(negedge clk);
        @(negedge clk);
        shutdown_ack = 1'b1;
        sb.push_back(mk("clean_ack", 2'b10, 0, 0, 1, DRAIN - 2));
        @(negedge clk);
        e = sb.pop_front(); got = snap(); tests++;
        if (got !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        shutdown_ack = 1'b0;
        timeout_in = 1'b0;
        sb.push_back(mk("clean_terminal", 2'b10, 0, 0, 1, DRAIN - 2));
        repeat (4) @(negedge clk);
        e = sb.pop_front(); got = snap(); tests++;
        if (got !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    endtask

    task automatic test_forced();
        exp_t e;
        logic [20:0] got;
        int n;
        int req_cycles;
        do_reset();
        timeout_in = 1'b1;
        wait_request(n);
        timeout_in = 1'b0;
        req_cycles = 1;
        for (int i = 0; i < 40 && state == 2'b01; i++) begin
            @(negedge clk);
            if (state == 2'b01) req_cycles++;
        end
        tests++;
        if (req_cycles != DRAIN + 1) begin fails++; $display("FAIL request_len: got %0d cycles expected %0d", req_cycles, DRAIN + 1); end
        sb.push_back(mk("forced", 2'b11, 1, 1, 1, 0));
        e = sb.pop_front(); got = snap(); tests++;
        if (got !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        shutdown_ack = 1'b1;
        sb.push_back(mk("forced_late_ack", 2'b11, 1, 1, 1, 0));
        repeat (3) @(negedge clk);
        e = sb.pop_front(); got = snap(); tests++;
        if (got !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        shutdown_ack = 1'b0;
    endtask

    task automatic test_ack_at_expiry();
        exp_t e;
        logic [20:0] got;
        int n;
        do_reset();
        timeout_in = 1'b1;
        wait_request(n);
        for (int i = 0; i < 40 && drain_count != '0; i++) @(negedge clk);
        tests++;
        if (state !== 2'b01 || drain_count !== '0) begin
            fails++;
            $display("FAIL expiry_reach: got state=%b count=%0d expected 01/0", state, drain_count);
        end
        shutdown_ack = 1'b1;
        sb.push_back(mk("ack_at_expiry", 2'b10, 0, 0, 1, 0));
        @(negedge clk);
        e = sb.pop_front(); got = snap(); tests++;
        if (got !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        shutdown_ack = 1'b0;
        timeout_in = 1'b0;
    endtask

    task automatic test_reset_mid_request();
        exp_t e;
        logic [20:0] got;
        int n;
        do_reset();
        timeout_in = 1'b1;
        wait_request(n);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        sb.push_back(mk("mid_reset", 2'b00, 0, 0, 0, 0));
        @(negedge clk);
        e = sb.pop_front(); got = snap(); tests++;
        if (got !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        reset_n = 1'b1;
        wait_request(n);
        tests++;
        if (n != SYNC + 1) begin fails++; $display("FAIL reentry: got %0d edges expected %0d", n, SYNC + 1); end
        sb.push_back(mk("reentry_state", 2'b01, 1, 0, 1, DRAIN));
        e = sb.pop_front(); got = snap(); tests++;
        if (got !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        timeout_in = 1'b0;
    endtask

    task automatic test_idle_ack_then_pulse();
        exp_t e;
        logic [20:0] got;
        int n;
        do_reset();
        shutdown_ack = 1'b1;
        sb.push_back(mk("idle_ack", 2'b00, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        e = sb.pop_front(); got = snap(); tests++;
        if (got !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        shutdown_ack = 1'b0;
        timeout_in = 1'b1;
        @(negedge clk);
        timeout_in = 1'b0;
        wait_request(n);
        sb.push_back(mk("pulse_capture", 2'b01, 1, 0, 1, DRAIN));
        e = sb.pop_front(); got = snap(); tests++;
        if (got !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    endtask

    initial begin
        test_reset();
        test_clean_ack();
        test_forced();
        test_ack_at_expiry();
        test_reset_mid_request();
        test_idle_ack_then_pulse();
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
